// File: rtl/xbar_pkg.sv
// Shared crossbar types: FSM encoding,
// command values and default bus widths.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select:
// first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic                           valid,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_MASTERS);

  always_comb begin
    int j;
    j         = 0;
    valid     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = (int'(ptr) + i) % NUM_MASTERS;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave arbitration stage: round-robin grant,
// forward to the slave, return ack and read data.
module slave_port_arbiter
  import xbar_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int IW = $clog2(NUM_MASTERS);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] win;
  logic          win_valid;
  logic          load;
  logic          done;
  logic          clr;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_arb (
    .req      (m_req),
    .ptr      (rr_ptr),
    .valid    (win_valid),
    .grant_idx(win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_valid) state_nxt = BUSY;
      BUSY:    if (s_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = (state == IDLE) && win_valid;
    done = (state == BUSY) && s_ack;
    clr  = (state == RESP);
  end

  // RESP never loads, so a held stale m_req cannot win again
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      grant   <= '0;
      s_req   <= 1'b0;
      s_cmd   <= CMD_READ;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ack   <= '0;
      m_rdata <= '0;
    end else begin
      if (load) begin
        grant   <= win;
        rr_ptr  <= (win == IW'(NUM_MASTERS-1))
                 ? '0 : win + 1'b1;
        s_req   <= 1'b1;
        s_cmd   <= m_cmd[win];
        s_addr  <= m_addr[win*ADDR_W +: ADDR_W];
        s_wdata <= m_wdata[win*DATA_W +: DATA_W];
      end
      if (done) begin
        s_req   <= 1'b0;
        m_rdata <= s_rdata;
        m_ack   <= NUM_MASTERS'(1) << grant;
      end
      if (clr) m_ack <= '0;
    end
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed table-driven bench for slave_port_arbiter
// with hand-written stale-request and reset sequences.
module tb_slave_port_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_cmd;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic [DW-1:0]    m_rdata;
  logic             s_req;
  logic             s_cmd;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_ack;
  logic [DW-1:0]    s_rdata;

  slave_port_arbiter #(
    .NUM_MASTERS(NM),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .m_req  (m_req),
    .m_cmd  (m_cmd),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_rdata(m_rdata),
    .s_req  (s_req),
    .s_cmd  (s_cmd),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_ack  (s_ack),
    .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] set;
    int            lat;
    logic [DW-1:0] rdata;
    int            exp;
    int            hold;
  } rec_t;

  rec_t          tbl[16];
  logic [AW-1:0] addr_of[NM];
  logic [DW-1:0] wdata_of[NM];
  logic          cmd_of[NM];
  logic [NM-1:0] pending;
  int            checks;
  int            errors;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run(input rec_t r);
    int            n;
    logic          seen;
    logic [NM-1:0] oh;
    oh        = '0;
    oh[r.exp] = 1'b1;
    @(negedge clk);
    pending = pending | r.set;
    m_req   = pending;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      seen = s_req;
    end
    check("grant_latency", 64'(n), 64'd1);
    check("s_addr", 64'(s_addr), 64'(addr_of[r.exp]));
    check("s_cmd", 64'(s_cmd), 64'(cmd_of[r.exp]));
    check("s_wdata", 64'(s_wdata), 64'(wdata_of[r.exp]));
    repeat (r.lat) @(posedge clk);
    @(negedge clk);
    check("busy_m_ack", 64'(m_ack), 64'd0);
    check("busy_s_req", 64'(s_req), 64'd1);
    check("busy_s_addr", 64'(s_addr), 64'(addr_of[r.exp]));
    s_ack   = 1'b1;
    s_rdata = r.rdata;
    @(posedge clk);
    #1;
    check("m_ack", 64'(m_ack), 64'(oh));
    check("m_rdata", 64'(m_rdata), 64'(r.rdata));
    check("s_req_drop", 64'(s_req), 64'd0);
    @(negedge clk);
    s_ack   = 1'b0;
    s_rdata = 32'hBAD0_BAD0;
    if (r.hold == 0) pending[r.exp] = 1'b0;
    m_req = pending;
    @(posedge clk);
    #1;
    check("m_ack_clear", 64'(m_ack), 64'd0);
    check("m_rdata_held", 64'(m_rdata), 64'(r.rdata));
    if (r.hold == 1) begin
      pending[r.exp] = 1'b0;
      m_req = pending;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    m_req   = '0;
    pending = '0;
    s_ack   = 1'b0;
    s_rdata = '0;

    addr_of[0]  = 32'h4;
    addr_of[1]  = 32'h8;
    addr_of[2]  = 32'h10;
    addr_of[3]  = 32'h1C;
    wdata_of[0] = 32'hA5A5_A5A5;
    wdata_of[1] = 32'h1111_1111;
    wdata_of[2] = 32'h2222_2222;
    wdata_of[3] = 32'h3333_3333;
    cmd_of[0]   = 1'b1;
    cmd_of[1]   = 1'b0;
    cmd_of[2]   = 1'b0;
    cmd_of[3]   = 1'b1;
    for (int i = 0; i < NM; i++) begin
      m_cmd[i]             = cmd_of[i];
      m_addr[i*AW +: AW]   = addr_of[i];
      m_wdata[i*DW +: DW]  = wdata_of[i];
    end

    // set, lat, rdata, expected master, hold
    tbl[0]  = '{4'b1111, 0, 32'h0000_0A00, 0, 0};
    tbl[1]  = '{4'b0000, 0, 32'h0000_0A01, 1, 0};
    tbl[2]  = '{4'b0000, 1, 32'h0000_0A02, 2, 0};
    tbl[3]  = '{4'b0000, 0, 32'h0000_0A03, 3, 0};
    tbl[4]  = '{4'b1111, 0, 32'h0000_0B00, 0, 0};
    tbl[5]  = '{4'b0000, 2, 32'h0000_0B01, 1, 0};
    tbl[6]  = '{4'b0000, 0, 32'h0000_0B02, 2, 0};
    tbl[7]  = '{4'b0000, 0, 32'h0000_0B03, 3, 0};
    tbl[8]  = '{4'b0100, 2, 32'hDEAD_BEEF, 2, 0};
    tbl[9]  = '{4'b0001, 0, 32'h1234_5678, 0, 0};
    tbl[10] = '{4'b1010, 0, 32'h0000_0C01, 1, 2};
    tbl[11] = '{4'b0000, 1, 32'h0000_0C03, 3, 2};
    tbl[12] = '{4'b0000, 0, 32'h0000_0C11, 1, 2};
    tbl[13] = '{4'b0000, 0, 32'h0000_0C13, 3, 0};
    tbl[14] = '{4'b0000, 0, 32'h0000_0C21, 1, 0};
    tbl[15] = '{4'b0010, 0, 32'h5A5A_0001, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_req", 64'(s_req), 64'd0);
    check("rst_s_cmd", 64'(s_cmd), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    check("rst_s_wdata", 64'(s_wdata), 64'd0);
    check("rst_m_ack", 64'(m_ack), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 16; k++) run(tbl[k]);

    // stale request from master 1 must not be re-granted
    repeat (4) begin
      @(posedge clk);
      #1;
      check("stale_s_req", 64'(s_req), 64'd0);
    end
    check("stale_rdata", 64'(m_rdata), 64'h5A5A_0001);

    // reset in BUSY, slave ack arrives afterwards
    @(negedge clk);
    m_req = 4'b0100;
    @(posedge clk);
    #1;
    check("rb_s_req", 64'(s_req), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rb_s_req0", 64'(s_req), 64'd0);
    check("rb_s_addr0", 64'(s_addr), 64'd0);
    check("rb_s_wdata0", 64'(s_wdata), 64'd0);
    check("rb_m_rdata0", 64'(m_rdata), 64'd0);
    check("rb_m_ack0", 64'(m_ack), 64'd0);
    m_req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    s_ack   = 1'b1;
    s_rdata = 32'hFEED_F00D;
    @(posedge clk);
    #1;
    check("rb_ign_ack", 64'(m_ack), 64'd0);
    check("rb_ign_rdata", 64'(m_rdata), 64'd0);
    @(negedge clk);
    s_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rb_idle_ack", 64'(m_ack), 64'd0);
      check("rb_idle_req", 64'(s_req), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_port_arbiter.md
# slave_port_arbiter

Per-slave arbitration stage of the crossbar, sitting directly downstream of the master port blocks. It accepts requests from `NUM_MASTERS` master ports, grants one at a time in round-robin order, and forwards the granted command, address and write data to a single slave. It then waits for the slave acknowledge and returns a one-cycle ack plus held read data to the granted master only.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of master ports; must be ≥ 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `m_req`  in  `NUM_MASTERS`  per-master request level; held until that master sees its ack.
- `m_cmd`  in  `NUM_MASTERS`  per-master command; 1 = write, 0 = read.
- `m_addr`  in  `NUM_MASTERS*ADDR_W`  flattened addresses; master i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `m_wdata`  in  `NUM_MASTERS*DATA_W`  flattened write data, same packing.
- `m_ack`  out  `NUM_MASTERS`  one-hot, one-cycle acknowledge to the granted master.
- `m_rdata`  out  `DATA_W`  read data broadcast to all masters; valid from the `m_ack` cycle until the next `s_ack`.
- `s_req`  out  1  request to the slave.
- `s_cmd`  out  1  forwarded command.
- `s_addr`  out  `ADDR_W`  forwarded address.
- `s_wdata`  out  `DATA_W`  forwarded write data.
- `s_ack`  in  1  slave acknowledge, one-cycle pulse; `s_rdata` is valid in the same cycle.
- `s_rdata`  in  `DATA_W`  slave read data.

## Operation
- FSM with three states: IDLE, BUSY, RESP.
- IDLE: if `m_req` ≠ 0, pick the winner: the first requesting index at or after `rr_ptr`, wrapping modulo `NUM_MASTERS`.
  - At the clock edge, register `grant` = winner, register `s_req`=1, and latch `s_cmd`/`s_addr`/`s_wdata` from the winner.
  - Set `rr_ptr` = (winner+1) mod `NUM_MASTERS` and move to BUSY.
  - If `m_req` = 0, stay in IDLE with `s_req`=0.
- BUSY: `s_*` outputs are held stable, and changes on `m_*` inputs are ignored.
  - On `s_ack`=1: `s_req`←0, `m_rdata`←`s_rdata` (captured for both reads and writes), `m_ack[grant]`←1, then move to RESP.
  - No timeout: BUSY waits indefinitely.
- RESP: `m_ack`←0 and move to IDLE. No arbitration happens in RESP. This gives the acked master one cycle to drop `m_req`, so a stale request cannot be re-granted.
- `s_ack` in IDLE or RESP is ignored.
- After each transaction, `s_cmd`, `s_addr` and `s_wdata` keep their last values; only `s_req` qualifies them.
- Reset values: state=IDLE, `rr_ptr`=0, `grant`=0, `s_req`=0, `s_cmd`=0, `s_addr`=0, `s_wdata`=0, `m_ack`=0, `m_rdata`=0.
- Reset mid-transaction: the transaction is dropped with no ack, and all outputs return to their reset values immediately (asynchronous reset).

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Request to slave: `m_req` sampled high at edge N in IDLE gives `s_req`=1 from edge N.
- Slave ack to master ack: `s_ack` sampled at edge M gives `m_ack` and `m_rdata` valid from edge M, for exactly one cycle of `m_ack`. The master samples `m_rdata` in the following cycle; it is still held then.
- Minimum transaction: request edge, slave ack at the next edge, RESP edge. The arbiter can accept a new grant at the edge after RESP, so the best case is 3 cycles per transaction.
- Simultaneous requests from all masters with `rr_ptr`=0 are served in order 0,1,2,3.

## Structure
- Shared package `xbar_pkg`:
  - state encoding: IDLE=2'b00, BUSY=2'b01, RESP=2'b10;
  - `CMD_WRITE`=1, `CMD_READ`=0;
  - default `ADDR_W` and `DATA_W`.
- Sub-module `rr_arbiter`: combinational winner select.
  - Inputs: `req[NUM_MASTERS]`, `ptr`.
  - Outputs: `valid`, `grant_idx` (width `$clog2(NUM_MASTERS)`).
- The FSM, input mux and output registers live in `slave_port_arbiter`.

## Test plan
- Single read: master 2 requests read at addr 0x10; slave acks 3 cycles later with rdata 0xDEADBEEF.
  - Required: `s_addr`=0x10, `s_cmd`=0; `m_ack`=4'b0100 for one cycle; `m_rdata`=0xDEADBEEF held.
- Single write: master 0 writes 0xA5A5A5A5 to 0x4.
  - Required: `s_wdata`=0xA5A5A5A5, `s_cmd`=1; `m_ack`=4'b0001 one cycle after `s_ack`.
- All four masters request simultaneously after reset.
  - Required: grants in order 0,1,2,3; the next burst after that also starts at 0.
- Round-robin fairness: masters 1 and 3 request continuously.
  - Required: grants alternate 1,3,1,3, and neither is starved.
- Stale request: master 1 holds `m_req` during the `m_ack` cycle, then drops it.
  - Required: no second grant to master 1.
- Reset asserted in BUSY, then `s_ack` arrives after release.
  - Required: all outputs are 0 during reset; `s_ack` is ignored in IDLE; no `m_ack` is produced.
